// File: rtl/bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// bus_arb_pkg
// Shared types for the memory bus arbiter: FSM state encoding, access size
// encoding and the latched request payload.
// -----------------------------------------------------------------------------
package bus_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic        wr;
        size_e       size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

endpackage

// File: rtl/arb_age_pick.sv
// -----------------------------------------------------------------------------
// arb_age_pick
// Per-requester age counters and winner selection. Fixed priority (index 0
// highest), except that any requester whose age has reached AGE_LIMIT is
// promoted above all non-aged requesters.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   req_i           request valid per requester
//   idle_i          arbiter is in S_IDLE (a grant is taken this cycle if any req)
//   cur_gnt_i       requester owning the in-flight transaction (used when !idle_i)
//   pick_idx_o      selected winner
//   pick_valid_o    at least one request pending
// -----------------------------------------------------------------------------
module arb_age_pick #(
    parameter int N_REQ     = 3,
    parameter int AGE_LIMIT = 15,
    parameter int AGE_W     = 4,
    parameter int IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req_i,
    input  logic             idle_i,
    input  logic [IDX_W-1:0] cur_gnt_i,
    output logic [IDX_W-1:0] pick_idx_o,
    output logic             pick_valid_o
);

    localparam logic [AGE_W-1:0] LIMIT = AGE_W'(AGE_LIMIT);

    logic [AGE_W-1:0] age_q [N_REQ];
    logic [AGE_W-1:0] age_d [N_REQ];
    logic             aged_hit;
    logic [IDX_W-1:0] aged_idx;

    // Scan from the highest index down so the lowest matching index is the
    // last one written and therefore wins.
    always_comb begin
        // NOTE: every signal driven here gets a default before any condition,
        // so no path leaves it unassigned and no latch is inferred.
        pick_valid_o = |req_i;
        pick_idx_o   = '0;
        aged_hit     = 1'b0;
        aged_idx     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                pick_idx_o = IDX_W'(i);
            end
            if (req_i[i] && (age_q[i] >= LIMIT)) begin
                aged_hit = 1'b1;
                aged_idx = IDX_W'(i);
            end
        end
        if (aged_hit) begin
            pick_idx_o = aged_idx;
        end
    end

    // Age only while actually waiting; the in-flight owner holds its value.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            age_d[i] = age_q[i];
            if (!req_i[i]) begin
                age_d[i] = '0;
            end else if (idle_i) begin
                if (pick_idx_o == IDX_W'(i)) begin
                    age_d[i] = '0;
                end else if (age_q[i] < LIMIT) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end else if ((cur_gnt_i != IDX_W'(i)) && (age_q[i] < LIMIT)) begin
                age_d[i] = age_q[i] + 1'b1;
            end
        end
    end

    // NOTE: the counters are a small register array, not RAM, and arbitration
    // depends on their value, so they are reset explicitly.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (!reset) begin
                age_q[i] <= '0;
            end else begin
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one sram-like memory port between N_REQ requesters (0 = uncached,
// 1 = dcache, 2 = icache) with one outstanding transaction at a time.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   m_req/m_wr/m_size/m_addr/m_wdata/m_wstrb   per-requester request + payload
//   m_addr_ok, m_data_ok       one-hot accept / completion pulses
//   m_rdata                    broadcast read data
//   bus_req + bus_* payload    downstream request (latched payload)
//   bus_addr_ok, bus_data_ok, bus_rdata        downstream handshake
//   proto_err                  sticky: bus_data_ok seen outside S_DATA
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int AGE_LIMIT = 15,
    parameter int AGE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   m_req,
    input  logic [N_REQ-1:0]   m_wr,
    input  logic [N_REQ*2-1:0] m_size,
    input  logic [N_REQ*32-1:0] m_addr,
    input  logic [N_REQ*32-1:0] m_wdata,
    input  logic [N_REQ*4-1:0] m_wstrb,
    output logic [N_REQ-1:0]   m_addr_ok,
    output logic [N_REQ-1:0]   m_data_ok,
    output logic [31:0]        m_rdata,
    output logic               bus_req,
    output logic               bus_wr,
    output logic [1:0]         bus_size,
    output logic [31:0]        bus_addr,
    output logic [31:0]        bus_wdata,
    output logic [3:0]         bus_wstrb,
    input  logic               bus_addr_ok,
    input  logic               bus_data_ok,
    input  logic [31:0]        bus_rdata,
    output logic               proto_err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    mem_req_t         pay_q, pay_d;
    logic             perr_q, perr_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    mem_req_t         pick_pay;

    arb_age_pick #(
        .N_REQ    (N_REQ),
        .AGE_LIMIT(AGE_LIMIT),
        .AGE_W    (AGE_W),
        .IDX_W    (IDX_W)
    ) u_pick (
        .clk         (clk),
        .reset       (reset),
        .req_i       (m_req),
        .idle_i      (state_q == S_IDLE),
        .cur_gnt_i   (gnt_q),
        .pick_idx_o  (pick_idx),
        .pick_valid_o(pick_valid)
    );

    // Payload mux for the current winner.
    always_comb begin
        pick_pay = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_pay.wr    = m_wr[i];
                pick_pay.size  = size_e'(m_size[2*i +: 2]);
                pick_pay.addr  = m_addr[32*i +: 32];
                pick_pay.wdata = m_wdata[32*i +: 32];
                pick_pay.wstrb = m_wstrb[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        pay_d     = pay_q;
        perr_d    = perr_q;
        bus_req   = 1'b0;
        m_addr_ok = '0;
        m_data_ok = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = S_ADDR;
                    gnt_d   = pick_idx;
                    pay_d   = pick_pay;
                end
                if (bus_data_ok) begin
                    perr_d = 1'b1;
                end
            end
            S_ADDR: begin
                bus_req = 1'b1;
                if (bus_addr_ok) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        m_addr_ok[i] = (gnt_q == IDX_W'(i));
                    end
                    state_d = S_DATA;
                end
                // A data_ok here (even alongside addr_ok) is never honoured.
                if (bus_data_ok) begin
                    perr_d = 1'b1;
                end
            end
            S_DATA: begin
                if (bus_data_ok) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        m_data_ok[i] = (gnt_q == IDX_W'(i));
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            pay_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            pay_q   <= pay_d;
            perr_q  <= perr_d;
        end
    end

    assign m_rdata   = bus_rdata;
    assign bus_wr    = pay_q.wr;
    assign bus_size  = pay_q.size;
    assign bus_addr  = pay_q.addr;
    assign bus_wdata = pay_q.wdata;
    assign bus_wstrb = pay_q.wstrb;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed scenarios followed by randomized traffic, all compared each cycle
// against a transaction-level reference model of the arbiter.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int AGE_LIMIT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  m_req, m_wr;
    logic [5:0]  m_size;
    logic [95:0] m_addr, m_wdata;
    logic [11:0] m_wstrb;
    logic [2:0]  m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        proto_err;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .m_req      (m_req),
        .m_wr       (m_wr),
        .m_size     (m_size),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_wstrb    (m_wstrb),
        .m_addr_ok  (m_addr_ok),
        .m_data_ok  (m_data_ok),
        .m_rdata    (m_rdata),
        .bus_req    (bus_req),
        .bus_wr     (bus_wr),
        .bus_size   (bus_size),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok),
        .bus_rdata  (bus_rdata),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (transaction level) ----------------
    bit          r_busy;      // a transaction is owned
    bit          r_adone;     // its address has been accepted
    int          r_g;         // owner
    logic [70:0] r_pl;        // {wr,size,addr,wdata,wstrb} presented downstream
    bit          r_perr;
    int          r_age [3];
    logic [2:0]  last_aok;

    function automatic logic [70:0] req_pl(int w);
        return {m_wr[w], m_size[2*w +: 2], m_addr[32*w +: 32],
                m_wdata[32*w +: 32], m_wstrb[4*w +: 4]};
    endfunction

    function automatic int pick();
        for (int i = 0; i < 3; i++) if (m_req[i] && r_age[i] >= AGE_LIMIT) return i;
        for (int i = 0; i < 3; i++) if (m_req[i]) return i;
        return -1;
    endfunction

    task automatic model_update();
        int w;
        if (!reset) begin
            r_busy = 0; r_adone = 0; r_g = 0; r_pl = '0; r_perr = 0;
            for (int i = 0; i < 3; i++) r_age[i] = 0;
            return;
        end
        if (bus_data_ok && !(r_busy && r_adone)) r_perr = 1;
        w = r_busy ? -1 : pick();
        for (int i = 0; i < 3; i++) begin
            if (!m_req[i])                    r_age[i] = 0;
            else if (!r_busy && i == w)       r_age[i] = 0;
            else if (!(r_busy && i == r_g))   r_age[i] = (r_age[i] < AGE_LIMIT) ? r_age[i] + 1 : AGE_LIMIT;
        end
        if (!r_busy) begin
            if (w >= 0) begin
                r_busy = 1; r_adone = 0; r_g = w; r_pl = req_pl(w);
            end
        end else if (!r_adone) begin
            if (bus_addr_ok) r_adone = 1;
        end else if (bus_data_ok) begin
            r_busy = 0;
        end
    endtask

    task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs mid-cycle against the model's prediction.
    task automatic look();
        logic [2:0] ea, ed;
        @(negedge clk);
        ea = (r_busy && !r_adone && bus_addr_ok) ? 3'(1 << r_g) : 3'b000;
        ed = (r_busy &&  r_adone && bus_data_ok) ? 3'(1 << r_g) : 3'b000;
        last_aok = ea;
        check("bus_req",   71'(bus_req), 71'(r_busy && !r_adone));
        check("payload",   {bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb}, r_pl);
        check("m_addr_ok", 71'(m_addr_ok), 71'(ea));
        check("m_data_ok", 71'(m_data_ok), 71'(ed));
        check("proto_err", 71'(proto_err), 71'(r_perr));
        if (ed != 3'b000) check("m_rdata", 71'(m_rdata), 71'(bus_rdata));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // ---------------- directed helpers ----------------
    task automatic grant();
        look();
        check("idle_bus_req", 71'(bus_req), 71'(0));
        cyc();
    endtask

    task automatic accept(input logic [2:0] exp_ok, input int stall);
        for (int k = 0; k < stall; k++) begin
            bus_addr_ok = 1'b0;
            look();
            check("stall_addr_ok", 71'(m_addr_ok), 71'(0));
            check("stall_bus_req", 71'(bus_req), 71'(1));
            cyc();
        end
        bus_addr_ok = 1'b1;
        look();
        check("addr_ok", 71'(m_addr_ok), 71'(exp_ok));
    endtask

    task automatic finish(input logic [31:0] rd, input logic [2:0] req_after,
                          input logic [2:0] exp_ok, input int dstall);
        cyc();
        bus_addr_ok = 1'b0;
        m_req       = req_after;
        for (int k = 0; k < dstall; k++) begin
            look();
            check("wait_data_ok", 71'(m_data_ok), 71'(0));
            cyc();
        end
        bus_data_ok = 1'b1;
        bus_rdata   = rd;
        look();
        check("data_ok", 71'(m_data_ok), 71'(exp_ok));
        check("rdata",   71'(m_rdata), 71'(rd));
        cyc();
        bus_data_ok = 1'b0;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        m_wr[i]          = wr;
        m_size[2*i +: 2] = sz;
        m_addr[32*i +: 32]  = a;
        m_wdata[32*i +: 32] = d;
        m_wstrb[4*i +: 4]   = s;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] exp_g, after;
        r_busy = 0; r_adone = 0; r_g = 0; r_pl = '0; r_perr = 0; last_aok = '0;
        for (int i = 0; i < 3; i++) r_age[i] = 0;
        reset = 1'b0; m_req = '0; m_wr = '0; m_size = '0; m_addr = '0;
        m_wdata = '0; m_wstrb = '0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;

        // Reset state
        cyc(); cyc();
        look();
        check("rst_bus_req",   71'(bus_req), 71'(0));
        check("rst_proto_err", 71'(proto_err), 71'(0));
        check("rst_bus_addr",  71'(bus_addr), 71'(0));
        cyc();
        reset = 1'b1;

        // 1: single icache read, addr_ok at cycle 3, data_ok at cycle 5
        set_req(2, 1'b0, 2'd2, 32'h1FC0_0000, 32'h0, 4'h0);
        m_req = 3'b100;
        grant();
        accept(3'b100, 1);
        check("t1_bus_addr", 71'(bus_addr), 71'(32'h1FC0_0000));
        finish(32'h3C08_BFC0, 3'b000, 3'b100, 1);

        // 2: collision, grant order 0,1,2
        set_req(0, 1'b1, 2'd2, 32'hBFAF_F000, 32'hCAFE_0001, 4'b0011);
        set_req(1, 1'b0, 2'd2, 32'h0000_1000, 32'h0, 4'h0);
        set_req(2, 1'b0, 2'd2, 32'h1FC0_0040, 32'h0, 4'h0);
        m_req = 3'b111;
        grant();
        accept(3'b001, 0);
        check("t2_bus_addr",  71'(bus_addr), 71'(32'hBFAF_F000));
        check("t2_bus_wstrb", 71'(bus_wstrb), 71'(4'b0011));
        check("t2_bus_wr",    71'(bus_wr), 71'(1));
        finish(32'h0, 3'b110, 3'b001, 0);
        grant(); accept(3'b010, 0); finish(32'h1111_2222, 3'b100, 3'b010, 0);
        grant(); accept(3'b100, 0); finish(32'h3333_4444, 3'b000, 3'b100, 0);

        // 3: starvation; req 2 wins on the 6th arbitration over req 0
        for (int n = 0; n < 6; n++) begin
            m_req = {1'b1, (n % 2 == 0) ? 2'b10 : 2'b01};
            exp_g = (n == 5) ? 3'b100 : ((n % 2 == 0) ? 3'b010 : 3'b001);
            after = (n == 5) ? 3'b101 : 3'b100;
            grant();
            accept(exp_g, 0);
            finish(32'(n), after, exp_g, 0);
        end
        check("t3_age2_cleared", 71'(dut.u_pick.age_q[2]), 71'(0));
        grant(); accept(3'b001, 0); finish(32'h0, 3'b100, 3'b001, 0);
        grant(); accept(3'b100, 0); finish(32'h0, 3'b000, 3'b100, 0);

        // 4: bus_addr_ok held low for 20 cycles
        set_req(1, 1'b1, 2'd1, 32'h8000_0102, 32'hA5A5_5A5A, 4'b1100);
        m_req = 3'b010;
        grant();
        accept(3'b010, 20);
        finish(32'h0, 3'b000, 3'b010, 0);

        // 5: reset while in S_DATA abandons the transaction
        m_req = 3'b001;
        set_req(0, 1'b0, 2'd0, 32'h0000_0042, 32'h0, 4'h0);
        grant();
        accept(3'b001, 0);
        cyc();
        bus_addr_ok = 1'b0; m_req = 3'b000;
        reset = 1'b0;
        look();
        check("t5_no_data_ok", 71'(m_data_ok), 71'(0));
        cyc();
        reset = 1'b1;
        look();
        check("t5_bus_req", 71'(bus_req), 71'(0));
        cyc();

        // 6: data_ok in S_IDLE -> sticky proto_err, no m_data_ok
        bus_data_ok = 1'b1;
        look();
        check("t6_no_data_ok", 71'(m_data_ok), 71'(0));
        cyc();
        bus_data_ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            look();
            check("t6_proto_sticky", 71'(proto_err), 71'(1));
            cyc();
        end
        reset = 1'b0; look(); cyc();
        reset = 1'b1; look();
        check("t6_proto_cleared", 71'(proto_err), 71'(0));
        cyc();

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            m_req = m_req & ~last_aok;
            for (int i = 0; i < 3; i++) begin
                if (!m_req[i] && $urandom_range(0, 2) == 0) begin
                    m_req[i] = 1'b1;
                    set_req(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                            $urandom, $urandom, 4'($urandom_range(0, 15)));
                end
            end
            bus_addr_ok = 1'($urandom_range(0, 1));
            bus_data_ok = (r_busy && r_adone) ? 1'($urandom_range(0, 1))
                                              : ($urandom_range(0, 49) == 0);
            bus_rdata   = $urandom;
            reset       = ($urandom_range(0, 199) != 0);
            look();
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
